backing_mem_ctrl: RTL and testbench
===================================

BACKING_MEM_CTRL -- requirements
Module: backing_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning word-index bits, giving 2^14 words (64 KiB).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request accept to mem_ready, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port mem_read, input, 1 bit: read request, held by requester until mem_ready.
REQ-006 SHALL have port mem_write, input, 1 bit: write request, held by requester until mem_ready.
REQ-007 SHALL have port mem_addr, input, 32 bits: byte address of the request.
REQ-008 SHALL have port mem_wdata, input, 32 bits: write data.
REQ-009 SHALL have port mem_rdata, output, 32 bits: read data.
REQ-010 SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or a posted write is pending.

Function
REQ-012 Storage SHALL be a 2^ADDR_WIDTH x 32-bit word array indexed by mem_addr[ADDR_WIDTH+1:2].
REQ-013 mem_addr[1:0] and bits above ADDR_WIDTH+1 SHALL be ignored (upper-address aliasing).
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 IDLE->BUSY SHALL occur when mem_read or mem_write is high; on that edge addr, wdata and op are captured and the counter is loaded with LATENCY-1.
REQ-016 In BUSY the counter SHALL decrement each cycle; when it is 0, mem_ready=1 for that cycle and the next state is DONE.
REQ-017 Request sampled in IDLE at cycle T SHALL produce mem_ready at cycle T+LATENCY.
REQ-018 A write SHALL update the array on the mem_ready edge, using the captured address and data.
REQ-019 For a read, mem_rdata SHALL present the array word in the mem_ready cycle and hold it until the next read completes.
REQ-020 DONE SHALL last exactly one cycle, ignore all requests, and go to IDLE, so a request still held in the mem_ready cycle is not re-accepted.
REQ-021 If mem_read and mem_write are both high at accept, the block SHALL perform the write and ignore the read.
REQ-022 Input changes while BUSY SHALL have no effect; only captured values are used.
REQ-023 mem_ready SHALL never be high in IDLE or DONE.
REQ-024 Minimum request-to-request spacing SHALL be LATENCY+2 cycles.

Reset
REQ-025 While reset=0, state=IDLE, counter=0, mem_ready=0, mem_rdata=0, busy=0, and the posted-write buffer is empty.
REQ-026 Array contents SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no array write and no mem_ready.
REQ-028 The first request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro MEM_POSTED_WRITE_EN SHALL add a one-entry posted-write buffer.
REQ-030 With MEM_POSTED_WRITE_EN defined and the buffer empty, a write accepted at T SHALL capture into the buffer, assert mem_ready at T+1, and go to DONE.
REQ-031 With MEM_POSTED_WRITE_EN defined, the buffer SHALL write the array LATENCY cycles after capture and then empty.
REQ-032 With MEM_POSTED_WRITE_EN defined, any request SHALL NOT be accepted while the buffer is full; it is accepted in the first IDLE cycle after the drain.
REQ-033 Without MEM_POSTED_WRITE_EN, writes SHALL follow REQ-015..018 and there is no buffer logic.

Verification
REQ-034 Scenario: LATENCY=4; write 0x0000_0040 <- 0xDEADBEEF at T -> mem_ready at T+4 only; read of the same address returns 0xDEADBEEF at its mem_ready.
REQ-035 Scenario: read held high for 3 cycles after mem_ready -> exactly one mem_ready; next accept occurs only after DONE.
REQ-036 Scenario: write 0x0004_0040 (aliases 0x40 with ADDR_WIDTH=14) <- 0x1234_5678 -> read 0x40 returns 0x1234_5678; addr 0x43 reads the same word.
REQ-037 Scenario: reset=0 at T+2 of a write -> mem_ready never pulses; the old word remains; outputs are 0.
REQ-038 Scenario: LATENCY=1, back-to-back reads -> mem_ready at T+1 and T+4.
REQ-039 Scenario: with MEM_POSTED_WRITE_EN, write at T then read of the same address -> write mem_ready at T+1; read accepted after drain at T+4 and returns the new data.

Source files
------------

// File: rtl/backing_mem_ctrl.sv
// -----------------------------------------------------------------------------
// backing_mem_ctrl
//
// Fixed-latency backing store of 2^ADDR_WIDTH 32-bit words behind a
// read/write request handshake. The requester holds mem_read or mem_write
// until a one-cycle mem_ready pulse. A request seen in IDLE finishes
// LATENCY cycles later. The controller then spends one DONE cycle before it
// can accept the next request.
//
// Optional feature: define MEM_POSTED_WRITE_EN to add a one-entry
// posted-write buffer. A write is then acknowledged one cycle after accept.
// The array is updated later, and no new request is accepted until the
// buffer has drained.
//
// Parameters:
//   ADDR_WIDTH  word-index bits (2^ADDR_WIDTH words), 1..29
//   LATENCY     cycles from request accept to mem_ready, 1..15
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   mem_read   read request, held until mem_ready
//   mem_write  write request, held until mem_ready (wins over mem_read)
//   mem_addr   byte address; only bits [ADDR_WIDTH+1:2] select the word
//   mem_wdata  write data
//   mem_rdata  read data, valid in the mem_ready cycle of a read and held
//              until the next read completes
//   mem_ready  one-cycle completion pulse
//   busy       controller not idle, or a posted write is still pending
// -----------------------------------------------------------------------------
module backing_mem_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  is_write_q, is_write_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  can_accept;
  logic                  mem_we;
  logic [31:0]           mem [DEPTH];
`ifdef MEM_POSTED_WRITE_EN
  logic                  pb_full_q, pb_full_d;
  logic [3:0]            pb_cnt_q, pb_cnt_d;
`endif

  // Word index of the incoming request. The byte offset and all address bits
  // above the array alias away.
  logic [ADDR_WIDTH-1:0] req_index;
  logic [31-ADDR_WIDTH:0] unused_addr_bits;
  assign req_index        = mem_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = {mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
`ifdef MEM_POSTED_WRITE_EN
    pb_full_d  = pb_full_q;
    pb_cnt_d   = pb_cnt_q;
    can_accept = !pb_full_q;
`else
    can_accept = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (can_accept && (mem_read || mem_write)) begin
          state_d    = BUSY;
          addr_d     = req_index;
          wdata_d    = mem_wdata;
          is_write_d = mem_write;   // write wins when both are requested
          cnt_d      = LAT_LOAD;
`ifdef MEM_POSTED_WRITE_EN
          // Posted write: acknowledge next cycle. addr_q/wdata_q double as
          // the buffer payload. They cannot be overwritten while the buffer
          // is full, because nothing is accepted until it drains.
          if (mem_write) begin
            cnt_d     = 4'd0;
            pb_full_d = 1'b1;
            pb_cnt_d  = LAT_LOAD;
          end
`endif
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
`ifndef MEM_POSTED_WRITE_EN
          mem_we  = is_write_q;     // array written on the mem_ready edge
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // DONE ignores requests, so a request still held through mem_ready is
      // not taken a second time.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MEM_POSTED_WRITE_EN
    // Drain the buffer so it is empty in the LATENCY-th cycle after capture.
    if (pb_full_q) begin
      if (pb_cnt_q <= 4'd1) begin
        mem_we    = 1'b1;
        pb_full_d = 1'b0;
      end else begin
        pb_cnt_d = pb_cnt_q - 4'd1;
      end
    end
`endif

    // Outputs are registered. They are computed from the next state, so they
    // line up with the cycle in which BUSY reaches a count of zero.
    ready_d = (state_d == BUSY) && (cnt_d == 4'd0);
    if (ready_d && !is_write_d) begin
      rdata_d = mem[addr_d];
    end
`ifdef MEM_POSTED_WRITE_EN
    busy_d = (state_d != IDLE) || pb_full_d;
`else
    busy_d = (state_d != IDLE);
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
`ifdef MEM_POSTED_WRITE_EN
      pb_full_q  <= 1'b0;
      pb_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
`ifdef MEM_POSTED_WRITE_EN
      pb_full_q  <= pb_full_d;
      pb_cnt_q   <= pb_cnt_d;
`endif
    end
  end

  // NOTE: the storage array has no reset. Contents survive reset, and only
  // the write enable (derived from reset flops) is cleared, which aborts any
  // in-flight write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_backing_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_backing_mem_ctrl
//
// Bench for backing_mem_ctrl. Instance A uses LATENCY=4 and instance B uses
// LATENCY=1. Both share clock and reset. A reference model tracks:
//   - expected memory contents, keyed by word index;
//   - the earliest cycle at which each instance can accept a new request;
//   - the last read data, which must be held across writes.
// Inputs are driven on the falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_backing_mem_ctrl;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;
`ifdef MEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        rd_i    [2];
  logic        wr_i    [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic [31:0] rdata_o [2];
  logic        ready_o [2];
  logic        busy_o  [2];

  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          next_free [2];
  logic [31:0] last_rd   [2];
  logic [31:0] ref_mem   [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  backing_mem_ctrl #(.ADDR_WIDTH(14), .LATENCY(LAT_A)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (rd_i[0]),
    .mem_write (wr_i[0]),
    .mem_addr  (addr_i[0]),
    .mem_wdata (wdata_i[0]),
    .mem_rdata (rdata_o[0]),
    .mem_ready (ready_o[0]),
    .busy      (busy_o[0])
  );

  backing_mem_ctrl #(.ADDR_WIDTH(14), .LATENCY(LAT_B)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (rd_i[1]),
    .mem_write (wr_i[1]),
    .mem_addr  (addr_i[1]),
    .mem_wdata (wdata_i[1]),
    .mem_rdata (rdata_o[1]),
    .mem_ready (ready_o[1]),
    .busy      (busy_o[1])
  );

  function automatic int lat_of(input int sel);
    return (sel == 0) ? LAT_A : LAT_B;
  endfunction

  // Word index from the byte address (14 index bits above the byte offset),
  // made unique per instance.
  function automatic int key_of(input int sel, input logic [31:0] addr);
    return sel * 65536 + int'((addr >> 2) & 32'h0000_3FFF);
  endfunction

  // Idle cycles. mem_ready must stay low throughout.
  task automatic idle_cycles(input int sel, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ready_o[sel] !== 1'b0) bad++;
    end
    if (n > 0) begin
      n_checks++;
      if (bad != 0)
        $display("FAIL idle_no_ready dut%0d cyc %0d: %0d stray mem_ready cycles, required 0",
                 sel, cyc, bad);
      else n_pass++;
    end
  endtask

  // Wait until the model says the instance can accept immediately.
  task automatic settle(input int sel);
    int n;
    n = next_free[sel] - cyc;
    if (n < 0) n = 0;
    idle_cycles(sel, n);
  endtask

  // One request, held until mem_ready. Called and returning on a falling
  // edge. Checks the completion cycle, busy after accept, and the data.
  task automatic do_req(input int sel, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit scramble, output int ready_cyc,
                        output logic [31:0] rdata_seen);
    int          acc;
    int          exp_ready;
    int          key;
    bit          seen;
    logic [31:0] exp_rdata;
    key       = key_of(sel, addr);
    acc       = (cyc > next_free[sel]) ? cyc : next_free[sel];
    exp_ready = acc + ((wr && POSTED) ? 1 : lat_of(sel));
    if (wr) exp_rdata = last_rd[sel];
    else if (ref_mem.exists(key)) exp_rdata = ref_mem[key];
    else exp_rdata = 32'h0;
    rd_i[sel]    = rd;
    wr_i[sel]    = wr;
    addr_i[sel]  = addr;
    wdata_i[sel] = data;
    seen         = 1'b0;
    ready_cyc    = -1;
    rdata_seen   = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (cyc == acc + 1) begin
        n_checks++;
        if (busy_o[sel] !== 1'b1)
          $display("FAIL busy_after_accept dut%0d cyc %0d: busy=%b, required 1",
                   sel, cyc, busy_o[sel]);
        else n_pass++;
      end
      if (ready_o[sel] === 1'b1) begin
        seen       = 1'b1;
        ready_cyc  = cyc;
        rdata_seen = rdata_o[sel];
      end else if (scramble && cyc > acc) begin
        // Inputs changing after accept must not matter.
        addr_i[sel]  = $urandom;
        wdata_i[sel] = $urandom;
      end
    end
    rd_i[sel] = 1'b0;
    wr_i[sel] = 1'b0;
    n_checks++;
    if (ready_cyc != exp_ready)
      $display("FAIL ready_cycle dut%0d %s addr %h: mem_ready at cycle %0d, required %0d",
               sel, wr ? "write" : "read", addr, ready_cyc, exp_ready);
    else n_pass++;
    n_checks++;
    if (rdata_seen !== exp_rdata)
      $display("FAIL %s dut%0d addr %h: mem_rdata=%h, required %h",
               wr ? "rdata_hold" : "read_data", sel, addr, rdata_seen, exp_rdata);
    else n_pass++;
    if (wr) ref_mem[key] = data;
    else last_rd[sel] = exp_rdata;
    next_free[sel] = exp_ready + 2;
    if (wr && POSTED && (acc + lat_of(sel) > next_free[sel]))
      next_free[sel] = acc + lat_of(sel);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rd_i[s] = 1'b0; wr_i[s] = 1'b0; addr_i[s] = '0; wdata_i[s] = '0;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (ready_o[s] !== 1'b0 || busy_o[s] !== 1'b0 || rdata_o[s] !== 32'h0)
        $display("FAIL reset_outputs dut%0d: ready=%b busy=%b rdata=%h, required 0 0 00000000",
                 s, ready_o[s], busy_o[s], rdata_o[s]);
      else n_pass++;
    end
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      next_free[s] = cyc;   // first edge after release accepts
      last_rd[s]   = 32'h0;
    end
  endtask

  task automatic test_basic();
    int          rc;
    logic [31:0] d;
    // Presented in the same cycle reset released: accepted on the first edge.
    do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, rc, d);
    do_req(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b0, rc, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF)
      $display("FAIL basic_read got %h, required deadbeef", d);
    else n_pass++;
  endtask

  task automatic test_alias();
    int          rc;
    logic [31:0] d;
    do_req(0, 1'b1, 1'b0, 32'h0004_0040, 32'h1234_5678, 1'b0, rc, d);
    do_req(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b0, rc, d);
    n_checks++;
    if (d !== 32'h1234_5678)
      $display("FAIL alias_read_40 got %h, required 12345678", d);
    else n_pass++;
    do_req(0, 1'b0, 1'b1, 32'h0000_0043, 32'h0, 1'b0, rc, d);
    n_checks++;
    if (d !== 32'h1234_5678)
      $display("FAIL alias_read_43 got %h, required 12345678", d);
    else n_pass++;
  endtask

  // Read held past mem_ready: one pulse, then re-accepted only from IDLE.
  task automatic test_held_request();
    int          t;
    int          r;
    int          stray;
    logic        b_done, b_idle, b_re, rdy2;
    logic [31:0] d2;
    logic [31:0] exp_d;
    settle(0);
    exp_d     = ref_mem[key_of(0, 32'h40)];
    t         = cyc;
    rd_i[0]   = 1'b1;
    wr_i[0]   = 1'b0;
    addr_i[0] = 32'h0000_0040;
    r         = -1;
    for (int k = 0; k < 40 && r < 0; k++) begin
      @(negedge clk);
      if (ready_o[0] === 1'b1) r = cyc;
    end
    n_checks++;
    if (r != t + LAT_A)
      $display("FAIL held_first_ready at cycle %0d, required %0d", r, t + LAT_A);
    else n_pass++;
    stray = 0; b_done = 1'b0; b_idle = 1'b1; b_re = 1'b0; rdy2 = 1'b0; d2 = '0;
    for (int k = 1; k <= LAT_A + 2; k++) begin
      @(negedge clk);
      if (k == 1) b_done = busy_o[0];
      if (k == 2) b_idle = busy_o[0];
      if (k == 3) begin
        b_re    = busy_o[0];
        rd_i[0] = 1'b0;
      end
      if (k < LAT_A + 2 && ready_o[0] !== 1'b0) stray++;
      if (k == LAT_A + 2) begin
        rdy2 = ready_o[0];
        d2   = rdata_o[0];
      end
    end
    n_checks++;
    if (stray != 0)
      $display("FAIL held_single_pulse: %0d extra mem_ready cycles, required 0", stray);
    else n_pass++;
    n_checks++;
    if ({b_done, b_idle, b_re} !== 3'b101)
      $display("FAIL held_busy_seq: done/idle/accept busy=%b%b%b, required 101",
               b_done, b_idle, b_re);
    else n_pass++;
    n_checks++;
    if (rdy2 !== 1'b1 || d2 !== exp_d)
      $display("FAIL held_reaccept: ready=%b rdata=%h, required 1 %h", rdy2, d2, exp_d);
    else n_pass++;
    last_rd[0]   = exp_d;
    next_free[0] = cyc + 2;
  endtask

  // Reset two cycles into a write: no completion, old word kept.
  task automatic test_reset_mid();
    int          rc;
    int          t;
    int          pulses;
    int          stray;
    logic [31:0] d;
    do_req(0, 1'b1, 1'b0, 32'h0000_0080, 32'h1111_1111, 1'b0, rc, d);
    settle(0);
    t          = cyc;
    wr_i[0]    = 1'b1;
    addr_i[0]  = 32'h0000_0080;
    wdata_i[0] = 32'h2222_2222;
    pulses     = 0;
    @(negedge clk);
    if (ready_o[0] === 1'b1) pulses++;
    @(negedge clk);
    if (ready_o[0] === 1'b1) pulses++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (pulses != (POSTED ? 1 : 0))
      $display("FAIL reset_mid_ready: %0d pulses before reset at cycle %0d, required %0d",
               pulses, t + 2, POSTED ? 1 : 0);
    else n_pass++;
    n_checks++;
    if (ready_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || rdata_o[0] !== 32'h0)
      $display("FAIL reset_mid_outputs: ready=%b busy=%b rdata=%h, required 0 0 00000000",
               ready_o[0], busy_o[0], rdata_o[0]);
    else n_pass++;
    wr_i[0] = 1'b0;
    stray   = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready_o[0] !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0)
      $display("FAIL reset_hold_ready: %0d mem_ready cycles in reset, required 0", stray);
    else n_pass++;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      next_free[s] = cyc;
      last_rd[s]   = 32'h0;
    end
    do_req(0, 1'b0, 1'b1, 32'h0000_0080, 32'h0, 1'b0, rc, d);
    n_checks++;
    if (d !== 32'h1111_1111)
      $display("FAIL reset_mid_old_word got %h, required 11111111", d);
    else n_pass++;
  endtask

  // Random traffic over a small word pool with aliased upper bits, random
  // byte offsets, input scrambling while busy and random gaps.
  task automatic test_random();
    int          pool [8];
    int          rc;
    int          op;
    int          idx;
    logic [31:0] d;
    logic [31:0] addr;
    for (int i = 0; i < 8; i++) pool[i] = $urandom_range(0, 16383);
    for (int i = 0; i < 8; i++) begin
      addr = ($urandom & 32'hFFFF_0000) | (32'(pool[i]) << 2) | 32'($urandom_range(0, 3));
      do_req(0, 1'b1, 1'b0, addr, $urandom, 1'b1, rc, d);
    end
    for (int n = 0; n < 40; n++) begin
      idx  = pool[$urandom_range(0, 7)];
      addr = ($urandom & 32'hFFFF_0000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      op   = $urandom_range(0, 2);
      case (op)
        0:       do_req(0, 1'b0, 1'b1, addr, $urandom, 1'b1, rc, d);
        1:       do_req(0, 1'b1, 1'b0, addr, $urandom, 1'b1, rc, d);
        default: do_req(0, 1'b1, 1'b1, addr, $urandom, 1'b1, rc, d);
      endcase
      idle_cycles(0, $urandom_range(0, 3));
    end
  endtask

  // LATENCY=1 instance: two reads back to back complete three cycles apart.
  task automatic test_back_to_back();
    int          rc;
    int          r1;
    int          r2;
    logic [31:0] d;
    logic [31:0] dat;
    dat = $urandom;
    do_req(1, 1'b1, 1'b0, 32'h0000_0100, dat, 1'b0, rc, d);
    do_req(1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, r1, d);
    n_checks++;
    if (d !== dat)
      $display("FAIL b2b_read_data got %h, required %h", d, dat);
    else n_pass++;
    do_req(1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, r2, d);
    n_checks++;
    if (r2 - r1 != 3)
      $display("FAIL b2b_spacing: mem_ready at %0d and %0d, required spacing 3", r1, r2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alias();
    test_held_request();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
